// File: rtl/scan_pkg.sv
// Shared types, sizes and the cyclic next-active-position search for the scan sequencers.
package scan_pkg;

  localparam int unsigned NUM_POS = 8;
  localparam int unsigned SEL_W   = 3;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StDwell
  } state_t;

  // Returns {wrapped, next}: first set bit of mask strictly above cur, searching 7->0 cyclically.
  // A lone set bit at cur yields next == cur with wrapped set; an empty mask returns cur unwrapped.
  function automatic logic [SEL_W:0] next_active(input logic [NUM_POS-1:0] mask,
                                                 input logic [SEL_W-1:0]   cur);
    logic [SEL_W-1:0] nxt;
    logic [SEL_W-1:0] idx;
    logic             found;
    nxt   = cur;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_POS; k++) begin
      // SEL_W-bit addition wraps modulo NUM_POS on its own
      idx = cur + SEL_W'(k);
      if (!found && mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
    return {found && (nxt <= cur), nxt};
  endfunction

endpackage

// File: rtl/scan_sel_gen_if.sv
// Scan sequencer bus: run/mask control toward the sequencer, decoder drive and status back.
interface scan_sel_gen_if;
  import scan_pkg::*;

  logic                 run;
  logic [NUM_POS-1:0]   digit_mask;
  logic [SEL_W-1:0]     sel;
  logic                 en;
  logic                 frame_done;
  logic                 busy;

  modport master (
    output run, digit_mask,
    input  sel, en, frame_done, busy
  );

  modport slave (
    input  run, digit_mask,
    output sel, en, frame_done, busy
  );

endinterface

// File: rtl/scan_next_sel.sv
// Combinational cyclic next-set-bit finder over the position mask.
module scan_next_sel
  import scan_pkg::*;
(
  input  logic [NUM_POS-1:0] mask,
  input  logic [SEL_W-1:0]   cur,
  output logic [SEL_W-1:0]   next,
  output logic               wrapped
);

  // Search upward from cur, wrapping past the top position
  always_comb begin
    {wrapped, next} = next_active(mask, cur);
  end

endmodule

// File: rtl/scan_sel_gen.sv
// Time-multiplexed scan sequencer: steps a 3-to-8 decoder through the masked positions,
// with a blanking gap (en low) before each dwell (en high).
module scan_sel_gen
  import scan_pkg::*;
#(
  parameter int unsigned DIV   = 1000,
  parameter int unsigned BLANK = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  scan_sel_gen_if.slave  bus
);

  localparam int unsigned CntMax = (DIV > BLANK) ? DIV : BLANK;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] DivLast   = CntW'(DIV - 1);
  // Unused when BLANK is zero; the blank state is then never entered
  localparam logic [CntW-1:0] BlankLast = CntW'((BLANK == 0) ? 0 : BLANK - 1);
  localparam state_t          StAfterSel = (BLANK == 0) ? StDwell : StBlank;

  state_t           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             en_q, en_d;
  logic             fd_q, fd_d;
  logic             busy_q, busy_d;

  logic [SEL_W-1:0] search_cur;
  logic [SEL_W-1:0] search_next;
  logic             search_wrapped;
  logic             mask_empty;

  // Searching above the top position from idle yields the lowest active position
  assign search_cur = (state_q == StIdle) ? SEL_W'(NUM_POS - 1) : sel_q;
  assign mask_empty = (bus.digit_mask == '0);

  scan_next_sel u_next_sel (
    .mask    (bus.digit_mask),
    .cur     (search_cur),
    .next    (search_next),
    .wrapped (search_wrapped)
  );

  // Next-state, counter and select update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    fd_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.run && !mask_empty) begin
          sel_d   = search_next;
          cnt_d   = '0;
          state_d = StAfterSel;
        end
      end
      StBlank: begin
        if (!bus.run) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == BlankLast) begin
          state_d = StDwell;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDwell: begin
        if (!bus.run) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DivLast) begin
          cnt_d = '0;
          if (mask_empty) begin
            state_d = StIdle;
          end else begin
            sel_d   = search_next;
            fd_d    = search_wrapped;
            state_d = StAfterSel;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so nothing combinational reaches a pin
  always_comb begin
    en_d   = (state_d == StDwell);
    busy_d = (state_d != StIdle);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.en         = en_q;
  assign bus.frame_done = fd_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Bench for scan_sel_gen: two instances (BLANK=2 and BLANK=0, DIV=4) sharing stimulus,
// a per-cycle scoreboard against a phase-based model, a table of scan-order scenarios
// and hand-written run-drop / mask-clear / async-reset sequences.
module tb_scan_sel_gen;

  localparam int Div = 4;

  typedef struct {
    logic [2:0] sel;
    logic       en;
    logic       fd;
    logic       busy;
  } exp_t;

  typedef struct {
    logic [7:0] mask;
    int         len;
    logic [2:0] seq [8];
    int         digits;
  } scen_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  scan_sel_gen_if bus0 ();
  scan_sel_gen_if bus1 ();

  scan_sel_gen #(.DIV(Div), .BLANK(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  scan_sel_gen #(.DIV(Div), .BLANK(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int n_cmp = 0;
  int n_err = 0;

  logic       cur_run;
  logic [7:0] cur_mask;

  // Reference model, one slot per instance
  int         mb [2] = '{2, 0};
  bit         m_act [2];
  int         m_phase [2];
  logic [2:0] m_sel [2];
  logic       m_fd [2];

  exp_t q0 [$];
  exp_t q1 [$];

  scen_t sc [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First set bit strictly above c, cyclically, found in a doubled copy of the mask
  function automatic logic [2:0] next_up(input logic [7:0] m, input logic [2:0] c);
    logic [15:0] dbl;
    dbl = {m, m};
    for (int k = 1; k <= 8; k++) begin
      if (dbl[int'(c) + k]) return 3'((int'(c) + k) % 8);
    end
    return c;
  endfunction

  task automatic set_in(input logic r, input logic [7:0] m);
    cur_run              = r;
    cur_mask             = m;
    bus0.run             = r;
    bus1.run             = r;
    bus0.digit_mask      = m;
    bus1.digit_mask      = m;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d]   = 1'b0;
      m_phase[d] = 0;
      m_sel[d]   = 3'd0;
      m_fd[d]    = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_step(input int d, output exp_t e);
    logic [2:0] nx;
    m_fd[d] = 1'b0;
    if (!m_act[d]) begin
      if (cur_run && cur_mask != 8'h00) begin
        m_act[d]   = 1'b1;
        m_phase[d] = 0;
        m_sel[d]   = next_up(cur_mask, 3'd7);
      end
    end else if (!cur_run) begin
      m_act[d]   = 1'b0;
      m_phase[d] = 0;
    end else begin
      m_phase[d]++;
      if (m_phase[d] == mb[d] + Div) begin
        m_phase[d] = 0;
        if (cur_mask == 8'h00) begin
          m_act[d] = 1'b0;
        end else begin
          nx       = next_up(cur_mask, m_sel[d]);
          m_fd[d]  = (nx <= m_sel[d]);
          m_sel[d] = nx;
        end
      end
    end
    e.sel  = m_sel[d];
    e.en   = m_act[d] && (m_phase[d] >= mb[d]);
    e.fd   = m_fd[d];
    e.busy = m_act[d];
  endtask

  // One clock: predict from current inputs, then compare both instances after the edge
  task automatic step();
    exp_t e0, e1;
    model_step(0, e0);
    model_step(1, e1);
    q0.push_back(e0);
    q1.push_back(e1);
    @(posedge clk);
    #1;
    e0 = q0.pop_front();
    e1 = q1.pop_front();
    chk("dut0.sel", 32'(bus0.sel), 32'(e0.sel));
    chk("dut0.en", 32'(bus0.en), 32'(e0.en));
    chk("dut0.frame_done", 32'(bus0.frame_done), 32'(e0.fd));
    chk("dut0.busy", 32'(bus0.busy), 32'(e0.busy));
    chk("dut1.sel", 32'(bus1.sel), 32'(e1.sel));
    chk("dut1.en", 32'(bus1.en), 32'(e1.en));
    chk("dut1.frame_done", 32'(bus1.frame_done), 32'(e1.fd));
    chk("dut1.busy", 32'(bus1.busy), 32'(e1.busy));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".dut0.sel"}, 32'(bus0.sel), 32'd0);
    chk({tag, ".dut0.en"}, 32'(bus0.en), 32'd0);
    chk({tag, ".dut0.frame_done"}, 32'(bus0.frame_done), 32'd0);
    chk({tag, ".dut0.busy"}, 32'(bus0.busy), 32'd0);
    chk({tag, ".dut1.sel"}, 32'(bus1.sel), 32'd0);
    chk({tag, ".dut1.en"}, 32'(bus1.en), 32'd0);
    chk({tag, ".dut1.frame_done"}, 32'(bus1.frame_done), 32'd0);
    chk({tag, ".dut1.busy"}, 32'(bus1.busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int cyc;
    logic prev_en;
    bit reached;

    sc[0].mask = 8'hFF; sc[0].len = 8; sc[0].digits = 10;
    sc[0].seq  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    sc[1].mask = 8'b1010_0100; sc[1].len = 3; sc[1].digits = 7;
    sc[1].seq  = '{3'd2, 3'd5, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    sc[2].mask = 8'h10; sc[2].len = 1; sc[2].digits = 4;
    sc[2].seq  = '{3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    sc[3].mask = 8'h81; sc[3].len = 2; sc[3].digits = 5;
    sc[3].seq  = '{3'd0, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};

    rst_n = 1'b0;
    set_in(1'b0, 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Async reset in the middle of a dwell clears outputs immediately
    set_in(1'b1, 8'hFF);
    repeat (5) step();
    chk("pre_reset.dut0.en", 32'(bus0.en), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    model_reset();
    set_in(1'b0, 8'hFF);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) step();

    // Scan-order scenarios: sel at each dwell start follows the table
    for (int s = 0; s < 4; s++) begin
      set_in(1'b0, sc[s].mask);
      repeat (2) step();
      set_in(1'b1, sc[s].mask);
      idx     = 0;
      prev_en = bus0.en;
      for (cyc = 0; cyc < sc[s].digits * 6 + 4; cyc++) begin
        step();
        if (bus0.en && !prev_en) begin
          if (idx < sc[s].digits)
            chk($sformatf("scan%0d.sel[%0d]", s, idx), 32'(bus0.sel),
                32'(sc[s].seq[idx % sc[s].len]));
          idx++;
        end
        if (s == 2) chk("blank0.single.en", 32'(bus1.en), 32'd1);
        prev_en = bus0.en;
      end
      chk($sformatf("scan%0d.digits_seen", s), 32'(idx >= sc[s].digits), 32'd1);
    end

    // Drop run on the second dwell cycle of sel=3, then restart from the lowest bit
    set_in(1'b0, 8'hFF);
    repeat (2) step();
    set_in(1'b1, 8'hFF);
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      step();
      if (m_act[0] && m_sel[0] == 3'd3 && m_phase[0] == 3) reached = 1'b1;
    end
    chk("run_drop.reached", 32'(reached), 32'd1);
    set_in(1'b0, 8'hFF);
    step();
    chk("run_drop.sel", 32'(bus0.sel), 32'd3);
    chk("run_drop.en", 32'(bus0.en), 32'd0);
    chk("run_drop.busy", 32'(bus0.busy), 32'd0);
    set_in(1'b1, 8'hFF);
    step();
    chk("restart.blank1.sel", 32'(bus0.sel), 32'd0);
    chk("restart.blank1.en", 32'(bus0.en), 32'd0);
    step();
    chk("restart.blank2.en", 32'(bus0.en), 32'd0);
    step();
    chk("restart.dwell.en", 32'(bus0.en), 32'd1);

    // Empty mask never starts; clearing the mask mid-dwell finishes the dwell then idles
    set_in(1'b0, 8'h00);
    repeat (2) step();
    set_in(1'b1, 8'h00);
    repeat (4) step();
    chk("empty_mask.busy", 32'(bus0.busy), 32'd0);
    set_in(1'b1, 8'hFF);
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      step();
      if (m_act[0] && m_sel[0] == 3'd5 && m_phase[0] == 2) reached = 1'b1;
    end
    chk("mask_clear.reached", 32'(reached), 32'd1);
    set_in(1'b1, 8'h00);
    repeat (3) step();
    chk("mask_clear.last_dwell.en", 32'(bus0.en), 32'd1);
    chk("mask_clear.last_dwell.sel", 32'(bus0.sel), 32'd5);
    step();
    chk("mask_clear.idle.en", 32'(bus0.en), 32'd0);
    chk("mask_clear.idle.busy", 32'(bus0.busy), 32'd0);
    chk("mask_clear.idle.frame_done", 32'(bus0.frame_done), 32'd0);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
